// File: rtl/pe_xnor_acc.sv
// pe_xnor_acc: multi-lane integer/XNOR dot-product processing element.
//
// Each valid beat forms a LANES-wide dot product. In integer mode the lanes
// use two's-complement weights and signed or zero-extended activations. In
// XNOR mode each lane contributes +1/-1. Beats accumulate into a saturating
// signed accumulator, and each tile emits one result with a valid pulse.
//
// Ports:
//   CLK, RST          clock (rising edge), async active-high reset
//   i_Valid           beat valid; every other input is ignored when low
//   i_First, i_Last   tile start / tile end markers
//   i_Bin             1 = XNOR mode, 0 = integer mode
//   i_SignI           integer mode: 1 = signed activations
//   Input_Feature     lane i at [i*BITS_A +: BITS_A]
//   Weight            lane i at [i*BITS_W +: BITS_W]
//   o_Valid           one-cycle pulse marking a new tile result
//   Output_PSUM       signed tile result, held between pulses
//   o_Sat             tile result was clamped, held between pulses

// Per-lane product: act x weight, or +1/-1 from the XNOR of the bit-0 values.
module pe_xnor_lane #(
    parameter int BITS_A = 2,
    parameter int BITS_W = 2
) (
    input  logic [BITS_A-1:0]            act,
    input  logic [BITS_W-1:0]            w,
    input  logic                         bin,
    input  logic                         sign_i,
    output logic signed [BITS_A+BITS_W:0] prod
);
    localparam int PW = BITS_A + BITS_W + 1;

    logic signed [BITS_A:0]   act_x;
    logic signed [BITS_W-1:0] w_s;

    // One extra bit lets an unsigned activation remain positive after signing.
    assign act_x = $signed({sign_i & act[BITS_A-1], act});
    assign w_s   = $signed(w);

    always_comb begin
        prod = '0;
        if (bin)
            prod = (act[0] ~^ w[0]) ? PW'(1) : -PW'(1);
        else
            prod = PW'(act_x) * PW'(w_s);
    end
endmodule

module pe_xnor_acc #(
    parameter int LANES    = 4,
    parameter int BITS_A   = 2,
    parameter int BITS_W   = 2,
    parameter int BITS_ACC = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       i_Valid,
    input  logic                       i_First,
    input  logic                       i_Last,
    input  logic                       i_Bin,
    input  logic                       i_SignI,
    input  logic [LANES*BITS_A-1:0]    Input_Feature,
    input  logic [LANES*BITS_W-1:0]    Weight,
    output logic                       o_Valid,
    output logic signed [BITS_ACC-1:0] Output_PSUM,
    output logic                       o_Sat
);
    localparam int PW = BITS_A + BITS_W + 1;
    localparam int SW = PW + $clog2(LANES);
    // The accumulator sum is one bit wider than its widest operand, so the
    // unclamped value is always exact before the range check.
    localparam int AW = ((BITS_ACC > SW) ? BITS_ACC : SW) + 1;

    localparam logic signed [BITS_ACC-1:0] ACC_MAX = {1'b0, {(BITS_ACC-1){1'b1}}};
    localparam logic signed [BITS_ACC-1:0] ACC_MIN = {1'b1, {(BITS_ACC-1){1'b0}}};

    logic [LANES-1:0][PW-1:0] prod;
    logic signed [SW-1:0]     beat_sum;

    // vld_pipe[1] = stage-1 beat valid, vld_pipe[2] = result pulse
    logic [2:1]               vld_pipe;
    logic                     s1_first, s1_last;
    logic signed [SW-1:0]     s1_sum;

    logic signed [BITS_ACC-1:0] acc, acc_clamp;
    logic                       sat_flag, sat_next, ovf;
    logic signed [AW-1:0]       acc_base, acc_next;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        pe_xnor_lane #(.BITS_A(BITS_A), .BITS_W(BITS_W)) u_lane (
            .act    (Input_Feature[g*BITS_A +: BITS_A]),
            .w      (Weight[g*BITS_W +: BITS_W]),
            .bin    (i_Bin),
            .sign_i (i_SignI),
            .prod   (prod[g])
        );
    end

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < LANES; i++)
            beat_sum = beat_sum + SW'($signed(prod[i]));
    end

    // Stage 1: register the beat sum and its tile markers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_pipe[1] <= 1'b0;
            s1_first    <= 1'b0;
            s1_last     <= 1'b0;
            s1_sum      <= '0;
        end else begin
            vld_pipe[1] <= i_Valid;
            if (i_Valid) begin
                s1_first <= i_First;
                s1_last  <= i_Last;
                s1_sum   <= beat_sum;
            end
        end
    end

    // Stage 2 datapath: a first beat restarts from 0 and clears the sticky flag.
    always_comb begin
        acc_base = s1_first ? '0 : AW'(acc);
        acc_next = acc_base + AW'(s1_sum);
        // The value is in range only if every bit from the sign bit up agrees.
        ovf      = !((&acc_next[AW-1:BITS_ACC-1]) || !(|acc_next[AW-1:BITS_ACC-1]));
        if (ovf)
            acc_clamp = acc_next[AW-1] ? ACC_MIN : ACC_MAX;
        else
            acc_clamp = acc_next[BITS_ACC-1:0];
        sat_next = (s1_first ? 1'b0 : sat_flag) | ovf;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_pipe[2] <= 1'b0;
            acc         <= '0;
            sat_flag    <= 1'b0;
            Output_PSUM <= '0;
            o_Sat       <= 1'b0;
        end else begin
            vld_pipe[2] <= vld_pipe[1] & s1_last;
            if (vld_pipe[1]) begin
                acc      <= acc_clamp;
                sat_flag <= sat_next;
                if (s1_last) begin
                    Output_PSUM <= acc_clamp;
                    o_Sat       <= sat_next;
                end
            end
        end
    end

    assign o_Valid = vld_pipe[2];
endmodule

// File: tb/tb_pe_xnor_acc.sv
// tb_pe_xnor_acc: directed plus random stimulus for pe_xnor_acc.
// Two instances share all inputs. One uses a 16-bit accumulator and the
// other an 8-bit accumulator, so saturation behaviour is exercised. Both are
// compared every cycle against a tile-level integer model.
module tb_pe_xnor_acc;
    localparam int L = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       i_Valid = 1'b0, i_First = 1'b0, i_Last = 1'b0, i_Bin = 1'b0, i_SignI = 1'b0;
    logic [7:0] Input_Feature = '0, Weight = '0;

    logic              v16, s16, v8, s8;
    logic signed [15:0] p16;
    logic signed [7:0]  p8;

    pe_xnor_acc #(.LANES(L), .BITS_A(2), .BITS_W(2), .BITS_ACC(16)) u_dut16 (
        .CLK(CLK), .RST(RST), .i_Valid(i_Valid), .i_First(i_First), .i_Last(i_Last),
        .i_Bin(i_Bin), .i_SignI(i_SignI), .Input_Feature(Input_Feature), .Weight(Weight),
        .o_Valid(v16), .Output_PSUM(p16), .o_Sat(s16));

    pe_xnor_acc #(.LANES(L), .BITS_A(2), .BITS_W(2), .BITS_ACC(8)) u_dut8 (
        .CLK(CLK), .RST(RST), .i_Valid(i_Valid), .i_First(i_First), .i_Last(i_Last),
        .i_Bin(i_Bin), .i_SignI(i_SignI), .Input_Feature(Input_Feature), .Weight(Weight),
        .o_Valid(v8), .Output_PSUM(p8), .o_Sat(s8));

    always #5 CLK = ~CLK;

    typedef struct {
        int due;
        int r16;
        bit t16;
        int r8;
        bit t8;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;
    int   m16 = 0, m8 = 0;
    bit   sat16 = 0, sat8 = 0;
    int   h16 = 0, h8 = 0;
    bit   hs16 = 0, hs8 = 0;

    always @(posedge CLK) cyc++;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int ref_sum(input bit bin, input bit sgn, input logic [7:0] f,
                                   input logic [7:0] w);
        int s = 0;
        for (int i = 0; i < L; i++) begin
            int a = int'(f[2*i +: 2]);
            int b = int'(w[2*i +: 2]);
            if (b >= 2) b -= 4;
            if (sgn && a >= 2) a -= 4;
            if (bin) s += (f[2*i] == w[2*i]) ? 1 : -1;
            else     s += a * b;
        end
        return s;
    endfunction

    function automatic int clampv(input int v, input int bits, output bit ov);
        int mx = (1 << (bits - 1)) - 1;
        int mn = -(1 << (bits - 1));
        ov = 1'b0;
        if (v > mx) begin ov = 1'b1; return mx; end
        if (v < mn) begin ov = 1'b1; return mn; end
        return v;
    endfunction

    // Tile-level model: a result is due two cycles after its last beat is driven.
    task automatic drive(input bit v, input bit f, input bit l, input bit bin, input bit sgn,
                         input logic [7:0] feat, input logic [7:0] wt);
        @(posedge CLK); #1;
        i_Valid = v; i_First = f; i_Last = l; i_Bin = bin; i_SignI = sgn;
        Input_Feature = feat; Weight = wt;
        if (v) begin
            int s;
            bit o1, o2;
            exp_t e;
            s = ref_sum(bin, sgn, feat, wt);
            if (f) begin m16 = 0; m8 = 0; sat16 = 0; sat8 = 0; end
            m16 = clampv(m16 + s, 16, o1); sat16 |= o1;
            m8  = clampv(m8 + s, 8, o2);   sat8  |= o2;
            if (l) begin
                e.due = cyc + 2; e.r16 = m16; e.t16 = sat16; e.r8 = m8; e.t8 = sat8;
                q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, $urandom, $urandom);
    endtask

    task automatic reset_pulse();
        @(posedge CLK); #1;
        RST = 1'b1; i_Valid = 1'b0;
        q.delete();
        m16 = 0; m8 = 0; sat16 = 0; sat8 = 0;
        h16 = 0; h8 = 0; hs16 = 0; hs8 = 0;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    // Every cycle: the pulse must match the schedule and the held outputs
    // must match the last delivered result.
    always @(negedge CLK) begin
        bit due;
        due = (q.size() > 0) && (q[0].due == cyc);
        chk("valid16", int'(v16), int'(due));
        chk("valid8",  int'(v8),  int'(due));
        if (due) begin
            h16 = q[0].r16; hs16 = q[0].t16; h8 = q[0].r8; hs8 = q[0].t8;
            void'(q.pop_front());
        end
        chk("psum16", int'(p16), h16);
        chk("sat16",  int'(s16), int'(hs16));
        chk("psum8",  int'(p8),  h8);
        chk("sat8",   int'(s8),  int'(hs8));
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // 1: integer unsigned, 3 x -2 per lane -> -24
        drive(1, 1, 1, 0, 0, 8'hFF, 8'hAA);
        idle(3);
        chk("t1_psum", int'(p16), -24);

        // 2: XNOR matched (+4), then half mismatched (0)
        drive(1, 1, 1, 1, 0, 8'h51, 8'h51);
        drive(1, 1, 1, 1, 0, 8'h51, 8'h15);
        idle(3);
        chk("t2_psum", int'(p16), 0);

        // 3: three +4 beats with gaps
        drive(1, 1, 0, 1, 0, 8'h55, 8'h55); idle(2);
        drive(1, 0, 0, 1, 0, 8'h55, 8'h55); idle(2);
        drive(1, 0, 1, 1, 0, 8'h55, 8'h55);
        idle(3);
        chk("t3_psum", int'(p16), 12);

        // 4: signed -2 x -2 x 4 = 16 per beat, 9 beats saturates the 8-bit unit
        for (int i = 0; i < 9; i++) drive(1, i == 0, i == 8, 0, 1, 8'hAA, 8'hAA);
        idle(3);
        chk("t4_psum8", int'(p8), 127);
        chk("t4_sat8", int'(s8), 1);
        chk("t4_psum16", int'(p16), 144);
        drive(1, 1, 1, 0, 1, 8'hAA, 8'hAA);
        idle(3);
        chk("t4b_psum8", int'(p8), 16);
        chk("t4b_sat8", int'(s8), 0);

        // 5: back-to-back 5 then -3; mid-tile restart discards a partial 8
        drive(1, 1, 1, 0, 0, 8'h0B, 8'h55);
        drive(1, 1, 1, 0, 0, 8'h03, 8'hFF);
        drive(1, 1, 0, 0, 0, 8'hAA, 8'h55);
        drive(1, 1, 0, 0, 0, 8'h00, 8'h55);
        drive(1, 0, 1, 0, 0, 8'h02, 8'h55);
        idle(3);
        chk("t5_psum", int'(p16), 2);

        // 6: reset in mid-tile, then a clean restart
        drive(1, 1, 0, 1, 0, 8'h55, 8'h55);
        drive(1, 0, 0, 1, 0, 8'h55, 8'h55);
        reset_pulse();
        drive(1, 1, 0, 0, 0, 8'h0B, 8'h55);
        drive(1, 0, 1, 0, 0, 8'h03, 8'hFF);
        idle(3);
        chk("t6_psum", int'(p16), 2);

        // random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) reset_pulse();
            else drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 1) == 1, $urandom, $urandom);
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
